// File: rtl/halfword_accumulator.sv
// Streaming signed accumulator: sums each group of NUM_TERMS halfwords modulo
// 2^HALFWORD_WIDTH and emits the sum with a sticky signed-overflow flag.
// The result slot overlaps term 0 of the next group for full throughput.
module halfword_accumulator #(
    parameter int unsigned HALFWORD_WIDTH = 16,
    parameter int unsigned NUM_TERMS      = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [HALFWORD_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [HALFWORD_WIDTH-1:0] out_data,
    output logic                      out_overflow,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned CntWidth = $clog2(NUM_TERMS) + 1;
    localparam int unsigned Msb      = HALFWORD_WIDTH - 1;

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e                    state_q, state_d;
    logic [HALFWORD_WIDTH-1:0] acc_q, acc_d;
    logic [CntWidth-1:0]       cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic [HALFWORD_WIDTH-1:0] out_data_q, out_data_d;
    logic                      out_ovf_q, out_ovf_d;
    logic                      out_valid_q, out_valid_d;

    logic                      in_hs;
    logic                      out_hs;
    logic [HALFWORD_WIDTH-1:0] sum;
    logic                      add_ovf;

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAccum;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Handshakes and the wrapped addition with its signed-overflow test
    always_comb begin
        in_hs   = in_valid && in_ready;
        out_hs  = out_valid_q && out_ready;
        sum     = acc_q + in_data;
        // Overflow only when both operands share a sign and the result flips it
        add_ovf = (acc_q[Msb] == in_data[Msb]) && (sum[Msb] != acc_q[Msb]);
    end

    // Next-state and accumulation
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StAccum: begin
                if (in_hs) begin
                    if (cnt_q == '0) begin
                        acc_d = in_data;
                        ovf_d = 1'b0;
                    end else begin
                        acc_d = sum;
                        ovf_d = ovf_q | add_ovf;
                    end
                    cnt_d = cnt_q + CntWidth'(1);
                    if (cnt_q == CntWidth'(NUM_TERMS - 1)) begin
                        out_data_d  = acc_d;
                        out_ovf_d   = ovf_d;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StHold;
                    end
                end
            end
            StHold: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    state_d     = StAccum;
                    // An input accepted here is term 0 of the next group
                    if (in_hs) begin
                        acc_d = in_data;
                        ovf_d = 1'b0;
                        cnt_d = CntWidth'(1);
                    end
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // Outputs: registered result, in_ready follows out_ready only in HOLD
    always_comb begin
        in_ready     = !rst && ((state_q == StAccum) || out_ready);
        out_data     = out_data_q;
        out_overflow = out_ovf_q;
        out_valid    = out_valid_q;
    end

endmodule

// File: tb/tb_halfword_accumulator.sv
// Self-checking bench for halfword_accumulator: scoreboard of expected group
// results compared against results captured at output handshakes.
module tb_halfword_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_overflow;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] stim[$];
    logic [15:0] exp_data[$];
    logic        exp_ovf[$];
    logic [15:0] obs_data[$];
    logic        obs_ovf[$];
    int          obs_cyc[$];
    int          in_cyc[$];

    halfword_accumulator #(
        .HALFWORD_WIDTH(16),
        .NUM_TERMS     (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_overflow(out_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture handshakes mid-cycle; they complete at the following rising edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_data.push_back(out_data);
            obs_ovf.push_back(out_overflow);
            obs_cyc.push_back(cyc);
        end
        if (!rst && in_valid && in_ready) in_cyc.push_back(cyc);
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_ovf.delete();
        obs_cyc.delete();
        in_cyc.delete();
    endtask

    task automatic add_terms(input int v, input int n);
        logic [31:0] w;
        w = v;
        for (int i = 0; i < n; i++) stim.push_back(w[15:0]);
    endtask

    // Reference: full-precision sum per step, overflow if out of 16-bit range
    task automatic push_expected();
        logic [15:0] acc;
        logic        ovf;
        int          wide;
        logic [31:0] ww;
        acc = stim[0];
        ovf = 1'b0;
        for (int i = 1; i < stim.size(); i++) begin
            wide = int'($signed(acc)) + int'($signed(stim[i]));
            if (wide > 32767 || wide < -32768) ovf = 1'b1;
            ww  = wide;
            acc = ww[15:0];
        end
        exp_data.push_back(acc);
        exp_ovf.push_back(ovf);
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic drive_term(input logic [15:0] t);
        int n;
        in_data  = t;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL drive_timeout: in_ready got %0b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_group(input bit expect_result);
        if (expect_result) push_expected();
        while (stim.size() > 0) drive_term(stim.pop_front());
    endtask

    task automatic check_results(input string name);
        int n;
        logic [15:0] ed;
        logic        eo;
        while (exp_data.size() > 0) begin
            ed = exp_data.pop_front();
            eo = exp_ovf.pop_front();
            n  = 0;
            while (obs_data.size() == 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            n_tests++;
            if (obs_data.size() == 0) begin
                n_fail++;
                $display("FAIL %s_timeout: no result, required data %h", name, ed);
            end else begin
                logic [15:0] od;
                logic        oo;
                od = obs_data.pop_front();
                oo = obs_ovf.pop_front();
                if (od !== ed) begin
                    n_fail++;
                    $display("FAIL %s_data: got %h, required %h", name, od, ed);
                end
                n_tests++;
                if (oo !== eo) begin
                    n_fail++;
                    $display("FAIL %s_ovf: got %0b, required %0b", name, oo, eo);
                end
            end
        end
        sync();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests += 4;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_in_ready: got %0b, required 0", in_ready);
        end
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid);
        end
        if (out_data !== 16'h0000) begin
            n_fail++; $display("FAIL rst_out_data: got %h, required 0000", out_data);
        end
        if (out_overflow !== 1'b0) begin
            n_fail++; $display("FAIL rst_out_ovf: got %0b, required 0", out_overflow);
        end
        sync();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_release_in_ready: got %0b, required 1", in_ready);
        end
        sync();
    endtask

    task automatic test_basic();
        clear_obs();
        for (int i = 1; i <= 9; i++) add_terms(i, 1);
        run_group(1'b1);
        check_results("basic");
        n_tests++;
        if (obs_cyc.size() == 0 && in_cyc.size() == 9) begin
            // result was already popped; latency is checked in back_to_back
        end
        if (in_cyc.size() !== 9) begin
            n_fail++; $display("FAIL basic_accepts: got %0d, required 9", in_cyc.size());
        end
    endtask

    task automatic test_negative();
        add_terms(-8, 1);
        add_terms(-6, 1);
        add_terms(0, 7);
        run_group(1'b1);
        check_results("negative");
    endtask

    task automatic test_overflow();
        add_terms(32767, 1);
        add_terms(1, 1);
        add_terms(0, 7);
        run_group(1'b1);
        add_terms(-32768, 2);
        add_terms(0, 7);
        run_group(1'b1);
        add_terms(32767, 1);
        add_terms(1, 1);
        add_terms(-1, 1);
        add_terms(0, 6);
        run_group(1'b1);
        check_results("overflow");
    endtask

    task automatic test_backpressure();
        clear_obs();
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) add_terms(i * 10, 1);
        run_group(1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests += 3;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_out_valid: got %0b, required 1", out_valid);
            end
            if (out_data !== exp_data[0]) begin
                n_fail++; $display("FAIL bp_out_data: got %h, required %h", out_data, exp_data[0]);
            end
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready: got %0b, required 0", in_ready);
            end
        end
        n_tests++;
        if (obs_data.size() !== 0) begin
            n_fail++; $display("FAIL bp_early_consume: got %0d results, required 0", obs_data.size());
        end
        sync();
        out_ready = 1'b1;
        check_results("backpressure");
    endtask

    task automatic test_back_to_back();
        clear_obs();
        add_terms(1, 9);
        push_expected();
        push_expected();
        add_terms(1, 9);
        while (stim.size() > 0) drive_term(stim.pop_front());
        repeat (3) @(negedge clk);
        n_tests += 2;
        if (obs_cyc.size() !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d results, required 2", obs_cyc.size());
        end else begin
            if (obs_cyc[1] - obs_cyc[0] !== 9) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d cycles, required 9", obs_cyc[1] - obs_cyc[0]);
            end
            n_tests++;
            if (in_cyc.size() < 10 || in_cyc[9] !== obs_cyc[0]) begin
                n_fail++;
                $display("FAIL b2b_overlap: term0 cycle %0d, required %0d",
                         (in_cyc.size() >= 10) ? in_cyc[9] : -1, obs_cyc[0]);
            end
            n_tests++;
            if (in_cyc.size() >= 9 && obs_cyc[0] !== in_cyc[8] + 1) begin
                n_fail++;
                $display("FAIL b2b_latency: got cycle %0d, required %0d", obs_cyc[0], in_cyc[8] + 1);
            end
        end
        check_results("back_to_back");
    endtask

    task automatic test_reset_mid_group();
        for (int i = 0; i < 4; i++) drive_term(16'd100);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_in_ready: got %0b, required 0", in_ready);
        end
        sync();
        rst = 1'b0;
        add_terms(2, 9);
        run_group(1'b1);
        check_results("reset_mid_group");
    endtask

    task automatic test_reset_hold();
        clear_obs();
        out_ready = 1'b0;
        add_terms(5, 9);
        run_group(1'b0);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        n_tests += 2;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_rst_out_valid: got %0b, required 0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_rst_in_ready: got %0b, required 1", in_ready);
        end
        sync();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs_data.size() !== 0) begin
            n_fail++; $display("FAIL hold_rst_dropped: got %0d results, required 0", obs_data.size());
        end
        sync();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_group();
        test_reset_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
